// File: rtl/alu_exec_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit_pkg
// Brief    : Shared opcodes, state encoding, port codes and helper functions
//            for the multi-cycle ALU execute stage.
// Revision : 1.0 - initial release
// ============================================================================
package alu_exec_unit_pkg;

  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;

  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;
  localparam logic [1:0] RW_IDLE  = 2'b00;

  localparam int CY_BIT = 1;
  localparam int Z_BIT  = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RDA_REQ = 3'd1,
    ST_RDA_CAP = 3'd2,
    ST_RDB_REQ = 3'd3,
    ST_RDB_CAP = 3'd4,
    ST_EXEC    = 3'd5,
    ST_WB      = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  function automatic logic op_is_legal(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_CMP);
  endfunction

  function automatic logic op_is_unary(input logic [3:0] op);
    return (op == OP_NOT) || (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_exec_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit_if
// Brief    : Instruction handshake and register-file port bundle of the
//            execute stage; master is the execute unit, slave its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface alu_exec_unit_if #(
  parameter int DATA_W = 8
);
  logic [7:0]        instr;
  logic              instr_valid;
  logic              instr_ready;
  logic              rf_strobe;
  logic [DATA_W-1:0] rf_word;
  logic [1:0]        rf_read_write;
  logic [1:0]        rf_rw_reg;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rf_rdata;
  logic [1:0]        flags;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  instr, instr_valid, rf_rdata,
    output instr_ready, rf_strobe, rf_word, rf_read_write, rf_rw_reg,
           rf_wdata, flags, busy, done, err
  );

  modport slave (
    output instr, instr_valid, rf_rdata,
    input  instr_ready, rf_strobe, rf_word, rf_read_write, rf_rw_reg,
           rf_wdata, flags, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/alu_exec_unit_alu_core.sv
`default_nettype none
// ============================================================================
// Module   : alu_core
// Brief    : Combinational datapath: result plus carry/borrow and zero flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_core
  import alu_exec_unit_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  wire logic [3:0]        op,
  input  wire logic [DATA_W-1:0] a,
  input  wire logic [DATA_W-1:0] b,
  output logic      [DATA_W-1:0] result,
  output logic                   cy,
  output logic                   z
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // bit DATA_W of the widened difference is the borrow, i.e. a < b unsigned
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    cy     = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        cy     = sum[DATA_W];
      end
      OP_SUB, OP_CMP: begin
        result = diff[DATA_W-1:0];
        cy     = diff[DATA_W];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        cy     = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        cy     = a[0];
      end
      default: begin
        result = '0;
        cy     = 1'b0;
      end
    endcase
    z = (result == '0);
  end

endmodule
`default_nettype wire

// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_unit
// Brief    : Multi-cycle ALU execute stage; reads operands and writes results
//            through the register file's strobed port, drives CY/Z flags.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int         DATA_W   = 8,
  parameter logic [7:0] NOP_WORD = 8'hF0
) (
  input wire logic        clk,
  input wire logic        rst,
  alu_exec_unit_if.master bus
);

  state_t            state_q, state_d;
  logic [7:0]        instr_q, instr_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;

  logic              instr_ready_q, instr_ready_d;
  logic              rf_strobe_q, rf_strobe_d;
  logic [DATA_W-1:0] rf_word_q, rf_word_d;
  logic [1:0]        rf_read_write_q, rf_read_write_d;
  logic [1:0]        rf_rw_reg_q, rf_rw_reg_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [1:0]        flags_q, flags_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] alu_result;
  logic              alu_cy;
  logic              alu_z;
  logic [3:0]        op_q;

  assign op_q = instr_q[7:4];

  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu_core (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .cy     (alu_cy),
    .z      (alu_z)
  );

  // Next state, operand capture and flag update
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    a_d        = a_q;
    b_d        = b_q;
    flags_d    = flags_q;
    err_d      = 1'b0;
    rf_wdata_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          if (op_is_legal(bus.instr[7:4])) begin
            state_d = ST_RDA_REQ;
          end else begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end
      // Read data is valid by the end of the strobe cycle, so the operand
      // register loads on the edge leaving the request state.
      ST_RDA_REQ: begin
        a_d     = bus.rf_rdata;
        state_d = ST_RDA_CAP;
      end
      ST_RDA_CAP: state_d = op_is_unary(op_q) ? ST_EXEC : ST_RDB_REQ;
      ST_RDB_REQ: begin
        b_d     = bus.rf_rdata;
        state_d = ST_RDB_CAP;
      end
      ST_RDB_CAP: state_d = ST_EXEC;
      ST_EXEC: begin
        flags_d[CY_BIT] = alu_cy;
        flags_d[Z_BIT]  = alu_z;
        if (op_q == OP_CMP) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_WB;
          rf_wdata_d = alu_result;
        end
      end
      ST_WB:   state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Port outputs are decoded from the next state so they register in step
  always_comb begin
    rf_strobe_d     = (state_d == ST_RDA_REQ) || (state_d == ST_RDB_REQ) ||
                      (state_d == ST_WB);
    rf_word_d       = rf_strobe_d ? NOP_WORD : '0;
    rf_read_write_d = RW_IDLE;
    rf_rw_reg_d     = 2'b00;
    case (state_d)
      ST_RDA_REQ: begin
        rf_read_write_d = RW_READ;
        rf_rw_reg_d     = instr_d[3:2];
      end
      ST_RDB_REQ: begin
        rf_read_write_d = RW_READ;
        rf_rw_reg_d     = instr_d[1:0];
      end
      ST_WB: begin
        rf_read_write_d = RW_WRITE;
        rf_rw_reg_d     = instr_d[3:2];
      end
      default: begin
        rf_read_write_d = RW_IDLE;
        rf_rw_reg_d     = 2'b00;
      end
    endcase
    instr_ready_d = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      instr_q         <= '0;
      a_q             <= '0;
      b_q             <= '0;
      instr_ready_q   <= 1'b1;
      rf_strobe_q     <= 1'b0;
      rf_word_q       <= '0;
      rf_read_write_q <= RW_IDLE;
      rf_rw_reg_q     <= 2'b00;
      rf_wdata_q      <= '0;
      flags_q         <= 2'b00;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      state_q         <= state_d;
      instr_q         <= instr_d;
      a_q             <= a_d;
      b_q             <= b_d;
      instr_ready_q   <= instr_ready_d;
      rf_strobe_q     <= rf_strobe_d;
      rf_word_q       <= rf_word_d;
      rf_read_write_q <= rf_read_write_d;
      rf_rw_reg_q     <= rf_rw_reg_d;
      rf_wdata_q      <= rf_wdata_d;
      flags_q         <= flags_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      err_q           <= err_d;
    end
  end

  assign bus.instr_ready   = instr_ready_q;
  assign bus.rf_strobe     = rf_strobe_q;
  assign bus.rf_word       = rf_word_q;
  assign bus.rf_read_write = rf_read_write_q;
  assign bus.rf_rw_reg     = rf_rw_reg_q;
  assign bus.rf_wdata      = rf_wdata_q;
  assign bus.flags         = flags_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.err           = err_q;

endmodule
`default_nettype wire
